// File: rtl/vliw_pkg.sv
// Shared VLIW constants and types: bundle geometry, instruction field widths and the NOP encoding.
package vliw_pkg;

  localparam int SLOTS    = 10;
  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int OPCODE_W = 5;
  localparam int REG_W    = 5;

  localparam logic [WORD_W-1:0] NOP_WORD = '0;

  typedef logic [SLOTS-1:0][WORD_W-1:0] bundle_t;

endpackage

// File: rtl/vliw_bundle_loader.sv
// Packs a valid/ready stream of slot instructions into SLOTS-wide bundles and writes each
// completed bundle to instruction memory at an auto-incrementing bundle address.
module vliw_bundle_loader #(
  parameter int                SLOTS     = vliw_pkg::SLOTS,
  parameter int                WORD_W    = vliw_pkg::WORD_W,
  parameter int                ADDR_W    = vliw_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WORD_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      imem_we,
  output logic [ADDR_W-1:0]         imem_addr,
  output logic [SLOTS*WORD_W-1:0]   imem_wdata,
  input  logic                      imem_ready,
  output logic                      done,
  output logic [15:0]               bundle_count
);
  import vliw_pkg::*;

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

  typedef enum logic {FILL, WRITE} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               slot_idx;
  logic [SLOTS-1:0][WORD_W-1:0]   buffer;
  logic [ADDR_W-1:0]              addr;
  logic                           last_flag;
  logic                           cfg_take;

  // A base-address load is only legal between bundles and wins over a word in the same cycle.
  assign cfg_take = (state == FILL) && cfg_valid && (slot_idx == '0);

  always_comb begin
    s_ready = (state == FILL) && !(cfg_valid && (slot_idx == '0));
  end

  assign imem_we    = (state == WRITE);
  assign imem_addr  = addr;
  assign imem_wdata = buffer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      slot_idx     <= '0;
      // NOTE: the bundle buffer is reset on purpose: unwritten slots must read as NOP, and the
      // buffer is also cleared after every write so short final bundles are NOP-padded.
      buffer       <= {SLOTS{WORD_W'(NOP_WORD)}};
      addr         <= BASE_ADDR;
      last_flag    <= 1'b0;
      done         <= 1'b0;
      bundle_count <= '0;
    end else begin
      // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
      done <= 1'b0;
      case (state)
        FILL: begin
          if (cfg_take) begin
            addr <= cfg_addr;
          end else if (s_valid) begin
            buffer[slot_idx] <= s_data;
            if ((slot_idx == LAST_IDX) || s_last) begin
              state     <= WRITE;
              last_flag <= s_last;
            end else begin
              slot_idx <= slot_idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          if (imem_ready) begin
            addr         <= addr + ADDR_W'(1);
            bundle_count <= bundle_count + 16'd1;
            buffer       <= {SLOTS{WORD_W'(NOP_WORD)}};
            slot_idx     <= '0;
            state        <= FILL;
            done         <= last_flag;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_bundle_loader.sv
// Self-checking bench: programs are turned into expected bundle writes by a queue-based model
// and compared against every imem write of the loader.
module tb_vliw_bundle_loader;

  localparam int SLOTS  = 10;
  localparam int WORD_W = 32;
  localparam int BW     = SLOTS * WORD_W;

  typedef struct packed {
    logic [31:0]   addr;
    logic [BW-1:0] data;
    logic          last;
  } wr_t;

  logic clk, rst_n;

  logic              cfg_valid, s_valid, s_ready, s_last, imem_we, imem_ready, done;
  logic [31:0]       cfg_addr, imem_addr, s_data;
  logic [BW-1:0]     imem_wdata;
  logic [15:0]       bundle_count;

  logic              cfg_valid4, s_valid4, s_ready4, s_last4, imem_we4, imem_ready4, done4;
  logic [3:0]        cfg_addr4, imem_addr4;
  logic [31:0]       s_data4;
  logic [BW-1:0]     imem_wdata4;
  logic [15:0]       bundle_count4;

  vliw_bundle_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .done(done), .bundle_count(bundle_count)
  );

  vliw_bundle_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid4), .cfg_addr(cfg_addr4),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_last(s_last4),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .imem_ready(imem_ready4), .done(done4), .bundle_count(bundle_count4)
  );

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  logic [31:0] model_addr;
  logic [15:0] exp_count;
  bit          pend_done;
  bit          ready_auto;
  bit          gaps;
  logic [3:0]  w4_addr[$];
  logic [BW-1:0] w4_data[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_auto) imem_ready = ($urandom_range(0, 3) != 0);
  end

  // Write monitor: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      pend_done = 1'b0;
    end else begin
      checks++;
      if (done !== pend_done) begin
        errors++;
        $display("FAIL done_pulse: got %b want %b at %0t", done, pend_done, $time);
      end
      pend_done = 1'b0;
      if (imem_we === 1'b1 && imem_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %h with no bundle expected", imem_addr);
        end else begin
          e = exp_q.pop_front();
          if (imem_addr !== e.addr) begin
            errors++;
            $display("FAIL write_addr: got %h want %h", imem_addr, e.addr);
          end
          checks++;
          if (imem_wdata !== e.data) begin
            errors++;
            $display("FAIL write_data: got %h want %h", imem_wdata, e.data);
          end
          pend_done = e.last;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_we4 === 1'b1 && imem_ready4 === 1'b1) begin
      w4_addr.push_back(imem_addr4);
      w4_data.push_back(imem_wdata4);
    end
  end

  // Model: program words split into SLOTS-word bundles, NOP-padded, at consecutive addresses.
  task automatic build_prog();
    int n  = words_q.size();
    int nb = (n + SLOTS - 1) / SLOTS;
    for (int b = 0; b < nb; b++) begin
      wr_t e;
      e.data = '0;
      for (int k = 0; k < SLOTS; k++)
        if (b * SLOTS + k < n) e.data[k*WORD_W +: WORD_W] = words_q[b*SLOTS+k];
      e.addr = model_addr;
      e.last = (b == nb - 1);
      exp_q.push_back(e);
      model_addr = model_addr + 32'd1;
      exp_count  = exp_count + 16'd1;
    end
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      n++;
      if (n > 300) begin
        errors++;
        $display("FAIL send_timeout: s_ready stuck at %b", s_ready);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 'x;
    s_last  = 1'b0;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_words(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(words_q[i], i == words_q.size() - 1);
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && imem_we === 1'b0) break;
      n++;
      if (n > 300) begin
        errors++;
        $display("FAIL drain_timeout: %0d bundles outstanding", exp_q.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_count(input string name);
    checks++;
    if (bundle_count !== exp_count) begin
      errors++;
      $display("FAIL %s_count: got %0d want %0d", name, bundle_count, exp_count);
    end
  endtask

  task automatic do_cfg(input logic [31:0] a);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    model_addr = a;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (imem_we !== 1'b0 || done !== 1'b0 || bundle_count !== 16'd0 ||
        imem_wdata !== '0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL %s: we=%b done=%b count=%0d addr=%h wdata=%h want all zero",
               name, imem_we, done, bundle_count, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 0; cfg_addr = 0; s_valid = 0; s_data = 'x; s_last = 0; imem_ready = 1;
    cfg_valid4 = 0; cfg_addr4 = 0; s_valid4 = 0; s_data4 = 'x; s_last4 = 0; imem_ready4 = 1;
    ready_auto = 0; gaps = 0; model_addr = 0; exp_count = 0;
    #12;
    check_reset_outputs("reset_values");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_bundle();
    do_cfg(32'd1);
    words_q = {32'hA080_0004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    build_prog();
    send_words(0, 9);
    drain();
    check_count("single_bundle");
  endtask

  task automatic test_short_bundle();
    words_q = {32'hA0C0_0005};
    build_prog();
    send_words(0, 0);
    drain();
    check_count("short_bundle");
  endtask

  task automatic test_multi_bundle();
    do_cfg(32'd3);
    words_q.delete();
    for (int i = 0; i < 25; i++) words_q.push_back(32'h4904_3000 + i);
    build_prog();
    send_words(0, 24);
    drain();
    check_count("multi_bundle");
  endtask

  task automatic test_stall();
    words_q.delete();
    for (int i = 0; i < 20; i++) words_q.push_back($urandom);
    build_prog();
    imem_ready = 1'b0;
    send_words(0, 9);
    s_valid = 1'b1;
    s_data  = words_q[10];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b1 || s_ready !== 1'b0 ||
          imem_addr !== exp_q[0].addr || imem_wdata !== exp_q[0].data) begin
        errors++;
        $display("FAIL stall_hold: we=%b s_ready=%b addr=%h want we=1 s_ready=0 addr=%h",
                 imem_we, s_ready, imem_addr, exp_q[0].addr);
      end
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    send_words(10, 19);
    drain();
    check_count("stall");
  endtask

  task automatic test_cfg();
    words_q.delete();
    for (int i = 0; i < 10; i++) words_q.push_back($urandom);
    build_prog();
    send_words(0, 2);
    cfg_valid = 1'b1;
    cfg_addr  = 32'h55;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_midbundle_ready: got %b want 1", s_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    send_words(3, 9);
    drain();

    words_q.delete();
    for (int i = 0; i < 10; i++) words_q.push_back($urandom);
    cfg_valid = 1'b1;
    cfg_addr  = 32'h77;
    s_valid   = 1'b1;
    s_data    = words_q[0];
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_priority_ready: got %b want 0", s_ready);
    end
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    model_addr = 32'h77;
    build_prog();
    send_words(0, 9);
    drain();
    check_count("cfg");
  endtask

  task automatic test_random();
    ready_auto = 1;
    gaps       = 1;
    for (int p = 0; p < 6; p++) begin
      int n = $urandom_range(1, 35);
      if (p == 2) begin
        do_cfg(32'hFFFF_FFFE);
        n = 25;
      end else if ($urandom_range(0, 1) == 1) begin
        do_cfg($urandom);
      end
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      build_prog();
      send_words(0, n - 1);
      drain();
    end
    ready_auto = 0;
    gaps       = 0;
    imem_ready = 1'b1;
    check_count("random");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) send(32'hDEAD_0000 + i, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_count  = 0;
    model_addr = 0;
    #1;
    check_reset_outputs("mid_reset_values");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_write: got %b want 0", imem_we);
      end
    end
    @(posedge clk); #1;
    words_q = {32'h1234_5678};
    build_prog();
    send_words(0, 0);
    drain();
    check_count("mid_reset");
  endtask

  task automatic test_addr_wrap4();
    int n;
    cfg_valid4 = 1'b1;
    cfg_addr4  = 4'd15;
    @(posedge clk); #1;
    cfg_valid4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid4 = 1'b1;
      s_data4  = 32'hC000_0000 + i;
      s_last4  = (i == 19);
      n = 0;
      forever begin
        @(negedge clk);
        if (s_ready4 === 1'b1) break;
        n++;
        if (n > 50) begin
          errors++;
          $display("FAIL wrap4_timeout: s_ready4 stuck at %b", s_ready4);
          break;
        end
      end
      @(posedge clk); #1;
    end
    s_valid4 = 1'b0;
    s_last4  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (w4_addr.size() !== 2) begin
      errors++;
      $display("FAIL wrap4_writes: got %0d writes want 2", w4_addr.size());
    end else begin
      checks++;
      if (w4_addr[0] !== 4'd15 || w4_addr[1] !== 4'd0) begin
        errors++;
        $display("FAIL wrap4_addr: got %h,%h want f,0", w4_addr[0], w4_addr[1]);
      end
      checks++;
      if (w4_data[0][31:0] !== 32'hC000_0000 || w4_data[0][BW-1 -: 32] !== 32'hC000_0009 ||
          w4_data[1][31:0] !== 32'hC000_000A) begin
        errors++;
        $display("FAIL wrap4_data: got %h / %h", w4_data[0], w4_data[1]);
      end
    end
    checks++;
    if (bundle_count4 !== 16'd2) begin
      errors++;
      $display("FAIL wrap4_count: got %0d want 2", bundle_count4);
    end
  endtask

  initial begin
    test_reset();
    test_single_bundle();
    test_short_bundle();
    test_multi_bundle();
    test_stall();
    test_cfg();
    test_random();
    test_mid_reset();
    test_addr_wrap4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
